// File: rtl/vending_core.sv
// Vending controller: edge-detected coins/buttons, saturating credit, per-item stock, coin-by-coin change payout.
// Inputs take effect at the sampling edge; change coins are held stable until change_ready accepts them.
module vending_core #(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 10,
    parameter int CREDIT_MAX = 999,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          coin_half,
    input  logic                          coin_one,
    input  logic                          coin_five,
    input  logic [NUM_ITEMS-1:0]          buy,
    input  logic                          refund,
    input  logic                          restock,
    input  logic [NUM_ITEMS*CREDIT_W-1:0] price_list,
    input  logic                          change_ready,
    output logic [CREDIT_W-1:0]           credit,
    output logic                          vend_valid,
    output logic [2:0]                    vend_item,
    output logic                          err_nocredit,
    output logic                          err_soldout,
    output logic                          coin_reject,
    output logic                          change_valid,
    output logic [1:0]                    change_coin,
    output logic                          refund_done,
    output logic [NUM_ITEMS-1:0]          stock_empty,
    output logic                          busy
);

    localparam int SUM_W = CREDIT_W + 2;

    typedef enum logic {IDLE, CHANGE} state_t;

    state_t                 state, state_nxt;
    logic                   prev_half, prev_one, prev_five, prev_refund, prev_restock;
    logic [NUM_ITEMS-1:0]   prev_buy;
    logic                   half_ev, one_ev, five_ev, refund_ev, restock_ev, coin_any, buy_any;
    logic [NUM_ITEMS-1:0]   buy_ev;
    logic [STOCK_W-1:0]     stock [NUM_ITEMS];

    logic [6:0]             coin_sum;
    logic [CREDIT_W-1:0]    credit_plus;
    logic [2:0]             sel_idx;
    logic [NUM_ITEMS-1:0]   sel_mask;
    logic [CREDIT_W-1:0]    sel_price;
    logic                   sel_empty;
    logic [1:0]             coin_sel;
    logic [CREDIT_W-1:0]    coin_val;

    logic [CREDIT_W-1:0]    credit_nxt;
    logic [2:0]             item_nxt;
    logic                   vend_nxt, nocredit_nxt, soldout_nxt, reject_nxt, done_nxt;
    logic                   do_vend, do_restock;

    function automatic logic [CREDIT_W-1:0] sat(input logic [SUM_W-1:0] v);
        return (v > SUM_W'(CREDIT_MAX)) ? CREDIT_W'(CREDIT_MAX) : v[CREDIT_W-1:0];
    endfunction

    assign half_ev    = coin_half & ~prev_half;
    assign one_ev     = coin_one  & ~prev_one;
    assign five_ev    = coin_five & ~prev_five;
    assign refund_ev  = refund    & ~prev_refund;
    assign restock_ev = restock   & ~prev_restock;
    assign buy_ev     = buy       & ~prev_buy;
    assign coin_any   = half_ev | one_ev | five_ev;
    assign buy_any    = |buy_ev;

    assign coin_sum    = (half_ev ? 7'd5 : 7'd0) + (one_ev ? 7'd10 : 7'd0) + (five_ev ? 7'd50 : 7'd0);
    assign credit_plus = sat(SUM_W'(credit) + SUM_W'(coin_sum));

    // Scan downward so the lowest-index pressed button is the one left selected.
    always_comb begin
        sel_idx   = '0;
        sel_mask  = '0;
        sel_price = '0;
        sel_empty = 1'b0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (buy_ev[i]) begin
                sel_idx     = 3'(i);
                sel_mask    = '0;
                sel_mask[i] = 1'b1;
                sel_price   = price_list[i*CREDIT_W +: CREDIT_W];
                sel_empty   = (stock[i] == '0);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_empty[i] = (stock[i] == '0);
        end
    end

    assign busy         = (state == CHANGE);
    assign change_valid = busy && (credit >= CREDIT_W'(5));
    assign change_coin  = change_valid ? coin_sel : 2'b00;

    always_comb begin
        coin_sel = 2'b01;
        coin_val = CREDIT_W'(5);
        if (credit >= CREDIT_W'(50)) begin
            coin_sel = 2'b11;
            coin_val = CREDIT_W'(50);
        end else if (credit >= CREDIT_W'(10)) begin
            coin_sel = 2'b10;
            coin_val = CREDIT_W'(10);
        end
    end

    always_comb begin
        state_nxt    = state;
        credit_nxt   = credit;
        item_nxt     = vend_item;
        vend_nxt     = 1'b0;
        nocredit_nxt = 1'b0;
        soldout_nxt  = 1'b0;
        reject_nxt   = 1'b0;
        done_nxt     = 1'b0;
        do_vend      = 1'b0;
        do_restock   = 1'b0;
        case (state)
            IDLE: begin
                do_restock = restock_ev;
                credit_nxt = credit_plus;
                if (refund_ev) begin
                    state_nxt = CHANGE;
                end else if (buy_any) begin
                    if (sel_empty) begin
                        soldout_nxt = 1'b1;
                    end else if (credit < sel_price) begin
                        nocredit_nxt = 1'b1;
                    end else begin
                        do_vend    = 1'b1;
                        vend_nxt   = 1'b1;
                        item_nxt   = sel_idx;
                        credit_nxt = sat(SUM_W'(credit) - SUM_W'(sel_price) + SUM_W'(coin_sum));
                    end
                end
            end
            CHANGE: begin
                reject_nxt = coin_any;
                if (!change_valid) begin
                    credit_nxt = '0;
                    done_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end else if (change_ready) begin
                    credit_nxt = credit - coin_val;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Edge-detect history resets high so buttons held through reset stay silent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit       <= '0;
            vend_valid   <= 1'b0;
            vend_item    <= '0;
            err_nocredit <= 1'b0;
            err_soldout  <= 1'b0;
            coin_reject  <= 1'b0;
            refund_done  <= 1'b0;
            prev_half    <= 1'b1;
            prev_one     <= 1'b1;
            prev_five    <= 1'b1;
            prev_refund  <= 1'b1;
            prev_restock <= 1'b1;
            prev_buy     <= '1;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            credit       <= credit_nxt;
            vend_valid   <= vend_nxt;
            vend_item    <= item_nxt;
            err_nocredit <= nocredit_nxt;
            err_soldout  <= soldout_nxt;
            coin_reject  <= reject_nxt;
            refund_done  <= done_nxt;
            prev_half    <= coin_half;
            prev_one     <= coin_one;
            prev_five    <= coin_five;
            prev_refund  <= refund;
            prev_restock <= restock;
            prev_buy     <= buy;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (do_restock) begin
                    stock[i] <= STOCK_W'(STOCK_INIT);
                end else if (do_vend && sel_mask[i]) begin
                    stock[i] <= stock[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vending_core.sv
// Directed bench for vending_core: coins, saturation, buys, sold-out/restock, change payout and reset.
module tb_vending_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coin_half, coin_one, coin_five, refund, restock, change_ready;
    logic [3:0]  buy;
    logic [39:0] price_list;
    logic [9:0]  credit;
    logic        vend_valid, err_nocredit, err_soldout, coin_reject, change_valid, refund_done, busy;
    logic [2:0]  vend_item;
    logic [1:0]  change_coin;
    logic [3:0]  stock_empty;

    int n_chk  = 0;
    int n_fail = 0;

    vending_core dut (
        .clk(clk), .rst_n(rst_n),
        .coin_half(coin_half), .coin_one(coin_one), .coin_five(coin_five),
        .buy(buy), .refund(refund), .restock(restock),
        .price_list(price_list), .change_ready(change_ready),
        .credit(credit), .vend_valid(vend_valid), .vend_item(vend_item),
        .err_nocredit(err_nocredit), .err_soldout(err_soldout), .coin_reject(coin_reject),
        .change_valid(change_valid), .change_coin(change_coin), .refund_done(refund_done),
        .stock_empty(stock_empty), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One tick to register released inputs, then one edge with the given inputs high.
    task automatic press(input logic h, input logic o, input logic f, input logic [3:0] b,
                         input logic rf, input logic rs);
        tick();
        coin_half = h; coin_one = o; coin_five = f; buy = b; refund = rf; restock = rs;
        tick();
        coin_half = 0; coin_one = 0; coin_five = 0; buy = '0; refund = 0; restock = 0;
    endtask

    initial begin
        logic seen;
        price_list = {10'd50, 10'd10, 10'd25, 10'd15};
        rst_n = 0; coin_half = 0; coin_one = 0; refund = 0; restock = 0; change_ready = 0;
        buy = '0;
        coin_five = 1;
        tick(); tick();
        chk("rst_credit", credit, 0);
        chk("rst_vend_valid", vend_valid, 0);
        chk("rst_vend_item", vend_item, 0);
        chk("rst_busy", busy, 0);
        chk("rst_change_valid", change_valid, 0);
        chk("rst_change_coin", change_coin, 0);
        chk("rst_stock_empty", stock_empty, 0);
        rst_n = 1;
        tick();
        chk("held_through_reset", credit, 0);
        coin_five = 0;

        press(0, 0, 1, 4'b0, 0, 0); chk("coin_five", credit, 50);
        press(0, 1, 0, 4'b0, 0, 0); chk("coin_one", credit, 60);
        press(1, 0, 0, 4'b0, 0, 0); chk("coin_half", credit, 65);

        for (int i = 0; i < 18; i++) press(0, 0, 1, 4'b0, 0, 0);
        for (int i = 0; i < 2; i++)  press(0, 1, 0, 4'b0, 0, 0);
        press(1, 0, 0, 4'b0, 0, 0);
        chk("credit_990", credit, 990);
        press(0, 0, 1, 4'b0, 0, 0);
        chk("saturate_999", credit, 999);

        press(0, 0, 0, 4'b0, 1, 0);
        chk("refund999_busy", busy, 1);
        chk("refund999_coin", change_coin, 3);
        change_ready = 1;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            seen = refund_done;
        end
        chk("refund999_done_seen", seen, 1);
        chk("refund999_credit", credit, 0);
        chk("refund999_idle", busy, 0);
        change_ready = 0;

        press(0, 1, 1, 4'b0, 0, 0);
        chk("coin_one_five_same", credit, 60);

        press(0, 0, 0, 4'b1000, 0, 0);
        chk("buy3_vend", vend_valid, 1);
        chk("buy3_item", vend_item, 3);
        chk("buy3_credit", credit, 10);
        press(1, 0, 0, 4'b0, 0, 0);
        chk("vend_pulse_end", vend_valid, 0);
        press(1, 0, 0, 4'b0, 0, 0);
        chk("credit_20", credit, 20);

        press(0, 0, 0, 4'b0001, 0, 0);
        chk("buy0_vend", vend_valid, 1);
        chk("buy0_item", vend_item, 0);
        chk("buy0_credit", credit, 5);
        press(0, 0, 0, 4'b0010, 0, 0);
        chk("buy1_nocredit", err_nocredit, 1);
        chk("buy1_no_vend", vend_valid, 0);
        chk("buy1_credit", credit, 5);

        press(0, 0, 1, 4'b0, 0, 0);
        chk("nocredit_pulse_end", err_nocredit, 0);
        for (int i = 0; i < 4; i++) press(0, 0, 0, 4'b0100, 0, 0);
        chk("buy2x4_not_empty", stock_empty, 4'b0000);
        chk("buy2x4_credit", credit, 15);
        press(0, 0, 0, 4'b0100, 0, 0);
        chk("buy2x5_empty", stock_empty, 4'b0100);
        chk("buy2x5_credit", credit, 5);
        press(0, 0, 0, 4'b0100, 0, 0);
        chk("soldout_err", err_soldout, 1);
        chk("soldout_not_nocredit", err_nocredit, 0);
        chk("soldout_credit", credit, 5);
        press(0, 0, 0, 4'b0, 0, 1);
        chk("soldout_pulse_end", err_soldout, 0);
        chk("restock_empty", stock_empty, 4'b0000);

        press(0, 0, 1, 4'b0100, 0, 0);
        chk("coin_buy_nocredit", err_nocredit, 1);
        chk("coin_buy_credit", credit, 55);
        press(0, 1, 0, 4'b0, 0, 0);
        chk("credit_65", credit, 65);

        press(0, 0, 0, 4'b0, 1, 0);
        chk("chg_busy", busy, 1);
        chk("chg_valid0", change_valid, 1);
        chk("chg_coin0", change_coin, 3);
        chk("chg_credit0", credit, 65);
        change_ready = 1;
        tick();
        chk("chg_credit1", credit, 15);
        chk("chg_coin1", change_coin, 2);
        change_ready = 0; coin_half = 1;
        tick();
        chk("chg_hold_credit", credit, 15);
        chk("chg_hold_coin", change_coin, 2);
        chk("chg_hold_valid", change_valid, 1);
        chk("chg_coin_reject", coin_reject, 1);
        coin_half = 0; change_ready = 1;
        tick();
        chk("chg_credit3", credit, 5);
        chk("chg_coin3", change_coin, 1);
        chk("chg_reject_end", coin_reject, 0);
        tick();
        chk("chg_credit4", credit, 0);
        chk("chg_valid4", change_valid, 0);
        chk("chg_coin4", change_coin, 0);
        chk("chg_done_early", refund_done, 0);
        tick();
        chk("chg_done", refund_done, 1);
        chk("chg_idle", busy, 0);
        chk("chg_done_credit", credit, 0);
        tick();
        chk("chg_done_pulse_end", refund_done, 0);
        change_ready = 0;

        press(0, 0, 1, 4'b0, 0, 0);
        chk("credit_50", credit, 50);
        press(0, 0, 0, 4'b0001, 1, 0);
        chk("refund_wins_no_vend", vend_valid, 0);
        chk("refund_wins_busy", busy, 1);
        chk("refund_wins_credit", credit, 50);
        rst_n = 0;
        tick();
        chk("midpay_rst_credit", credit, 0);
        chk("midpay_rst_valid", change_valid, 0);
        chk("midpay_rst_busy", busy, 0);
        chk("midpay_rst_done", refund_done, 0);
        rst_n = 1;
        tick();
        chk("after_rst_done", refund_done, 0);
        chk("after_rst_stock", stock_empty, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vending_core.md
# vending_core

Parametrised vending-machine controller for the selling-machine design. It accepts 0.5/1/5 coin button inputs and N product-select buttons with per-item prices and stock counts, and keeps a saturating credit. On refund it pays change back out coin by coin through a valid/ready handshake. It sits between the button debouncers/clock divider and the 7-segment display driver, which shows `credit`.

## Interface
Parameters:
- NUM_ITEMS, 4, number of products (1..8)
- CREDIT_W, 10, credit width; unit is 0.1 yuan
- CREDIT_MAX, 999, credit saturation value (must be < 2^CREDIT_W)
- STOCK_W, 4, per-item stock counter width
- STOCK_INIT, 5, stock loaded at reset and on restock

Ports (all synchronous to clk):
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- coin_half, coin_one, coin_five  in  1 each  coin buttons, level; event on 0→1 transition
- buy  in  NUM_ITEMS  product buttons, level; event on 0→1 per bit
- refund, restock  in  1 each  level; event on 0→1
- price_list  in  NUM_ITEMS*CREDIT_W  item i price at bits [i*CREDIT_W +: CREDIT_W]; static, multiple of 5
- change_ready  in  1  coin hopper accepts current change coin
- credit  out  CREDIT_W  current credit
- vend_valid  out  1  one-cycle pulse, item dispensed
- vend_item  out  3  index of dispensed item, held until next vend
- err_nocredit, err_soldout  out  1 each  one-cycle pulse on rejected buy
- coin_reject  out  1  one-cycle pulse, coin event ignored while busy
- change_valid  out  1  change coin offered
- change_coin  out  2  01 = 0.5, 10 = 1, 11 = 5; 00 when idle
- refund_done  out  1  one-cycle pulse, change payout complete
- stock_empty  out  NUM_ITEMS  bit i = stock of item i is 0
- busy  out  1  high in CHANGE state

## Operation
- Edge detect: every button input has a prev register. An event fires when the input is 1 and prev is 0. Prev registers reset to 1, so a button held through reset release does not produce an event.
- FSM states: IDLE, CHANGE.
- IDLE, per cycle:
  - All coin events in the same cycle are summed (5/10/50) and added to credit.
  - The result saturates at CREDIT_MAX. No error is raised on saturation.
  - Refund event has priority over any buy. It enters CHANGE and this cycle's coins are still added.
  - Otherwise the lowest-index buy event is taken; other simultaneous buys are dropped.
  - Buy checks are done in order:
    - stock 0: err_soldout, no other effect.
    - registered credit < price: err_nocredit.
    - otherwise: credit_next = sat(credit − price + coins), stock decremented, vend_valid, vend_item = i.
  - Restock event (IDLE only) loads every stock to STOCK_INIT. It is ignored in CHANGE.
- CHANGE:
  - change_valid = 1 while credit ≥ 5.
  - change_coin selects the largest coin ≤ credit: 5 (≥50), 1 (≥10), else 0.5.
  - On a cycle with change_valid & change_ready, credit decreases by the coin value.
  - When credit < 5 (including 0 on entry): credit cleared to 0, refund_done pulsed, return to IDLE, change_valid 0.
  - Coin events: coin_reject pulse, credit unchanged. Buy and refund events ignored.
- change_coin and change_valid are stable while change_valid = 1 and change_ready = 0.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - State IDLE; credit 0; all pulses 0; vend_item 0; change_valid 0; change_coin 00; busy 0.
  - All stock = STOCK_INIT, so stock_empty = 0. Prev registers = 1.
- Reset mid-payout abandons the remaining change with no refund_done.
- Latency: an input sampled 1 at edge k (0 at edge k−1) takes effect at edge k. Outputs and credit update after edge k.
- Pulses (vend_valid, err_*, coin_reject, refund_done) last exactly one clock.
- Refund at edge k: busy and change_valid high after edge k. First coin accepted at the earliest edge k+1.
- Payout rate: maximum one coin per clock with change_ready held high.
- Subtraction never underflows. The compare is done on registered credit before the coin add.

## Test plan
- Reset, then coin_five, coin_one, coin_half rising on separate cycles → credit 50, 60, 65. Inputs held high through reset → no event.
- Credit 990, coin_five → credit 999. Coin_one and coin_five in the same cycle from 0 → credit 60.
- price_list {25,15,...}, credit 20, buy[0] → vend_valid, vend_item 0, credit 5, stock[0] 4. Then buy[1] → err_nocredit, credit 5.
- Buy item 2 five times with ample credit → stock_empty[2] = 1. Sixth buy → err_soldout. Restock → stock_empty[2] = 0.
- Credit 65, refund, change_ready toggling 1,0,1,1 → coins 5, (hold), 1, 0.5. Then refund_done, credit 0. Coin during payout → coin_reject, credit unaffected.
- Refund and buy[0] in the same cycle → refund wins, no vend. rst_n low mid-payout → credit 0, change_valid 0, no refund_done.
